hazard_wb_unit: RTL and testbench
=================================

HAZARD_WB_UNIT -- requirements
Module: hazard_wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of register values.
REQ-002 SHALL have parameter NREGS, default 32, register count; RW = clog2(NREGS) is the register address width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports id_rs1_v, id_rs2_v  input  1  decode-stage source operand valid.
REQ-006 SHALL have ports id_rs1, id_rs2  input  RW  decode-stage source register addresses.
REQ-007 SHALL have ports ex_wr, ex_is_load  input  1  exec stage writes rd; exec-stage instruction is a load.
REQ-008 SHALL have ports ex_rd  input  RW and ex_result  input  XLEN  exec-stage destination and ALU result.
REQ-009 SHALL have ports mem_wr  input  1, mem_rd  input  RW, mem_result  input  XLEN  memacc-stage destination and final value (load data or ALU result).
REQ-010 SHALL have ports rs1_data, rs2_data  output  XLEN  resolved operands for exec.
REQ-011 SHALL have port stall  output  1  hold fetch/decode, inject bubble into exec.
REQ-012 SHALL have port stall_cnt  output  16  saturating count of stall cycles.

Function
REQ-013 SHALL hold NREGS x XLEN register file; register 0 reads 0 always, writes to it ignored.
REQ-014 SHALL capture {mem_wr, mem_rd, mem_result} into WB register (wb_wr, wb_rd, wb_data) each posedge.
REQ-015 SHALL write wb_data to regfile[wb_rd] at posedge when wb_wr=1 and wb_rd!=0.
REQ-016 SHALL read regfile combinationally; same-cycle read of wb_rd returns wb_data (write-through bypass).
REQ-017 SHALL (FWD_EN) resolve each operand with priority: EX (ex_wr, ex_rd match, not load) > MEM (mem_wr, mem_rd match) > WB > regfile.
REQ-018 SHALL treat a match only when operand valid=1 and address!=0; invalid operand output = 0.
REQ-019 SHALL assert stall combinationally when a valid operand (addr!=0) matches ex_rd with ex_wr=1 and ex_is_load=1 (load-use, 1 cycle).
REQ-020 SHALL, when stall=1, drive rs1_data/rs2_data = 0 (bubble operands).
REQ-021 SHALL increment stall_cnt at posedge when stall=1; hold at 16'hFFFF (no wrap).
REQ-022 SHALL make both operands hitting the same stage forward the same value; rs1==rs2 legal.
REQ-023 SHALL give the EX stage precedence when EX and MEM both target the same rd (youngest wins).

Reset
REQ-024 SHALL on rst_n=0 asynchronously clear all regfile entries, wb_wr, wb_rd, wb_data and stall_cnt to 0.
REQ-025 SHALL hold state during reset; first regfile write no earlier than second posedge after rst_n rises (WB capture, then write).
REQ-026 SHALL produce stall from current inputs even during reset (purely combinational).

Configuration
REQ-027 SHALL support macro HAZARD_WB_UNIT_FWD_EN: defined -> EX/MEM/WB forwarding per REQ-017, stall only on load-use.
REQ-028 SHALL without HAZARD_WB_UNIT_FWD_EN: no EX/MEM forwarding; stall whenever a valid nonzero operand matches ex_rd (ex_wr) or mem_rd (mem_wr); WB bypass (REQ-016) retained.

Verification
REQ-029 SHALL cover reset: assert rst_n=0 mid-run after writing x5=0x1234 -> x5 reads 0, stall_cnt=0.
REQ-030 SHALL cover EX forwarding (FWD_EN): ex_wr=1, ex_rd=3, ex_result=0xAA, id_rs1=3 -> rs1_data=0xAA, stall=0.
REQ-031 SHALL cover priority: ex_rd=mem_rd=7, ex_result=1, mem_result=2, id_rs2=7 -> rs2_data=1.
REQ-032 SHALL cover load-use: ex_is_load=1, ex_rd=4, id_rs1=4 -> stall=1 one cycle, stall_cnt +1, operands 0.
REQ-033 SHALL cover x0: mem_wr=1, mem_rd=0, mem_result=0xFF, id_rs1=0 -> rs1_data=0, regfile[0]=0 after 2 cycles.
REQ-034 SHALL cover saturation and no-forward build: 70000 forced stall cycles -> stall_cnt=0xFFFF; without macro, mem_rd=9 match -> stall=1.

Source files
------------

// File: rtl/hazard_wb_unit_if.sv
// hazard_wb_unit_if: decode/exec/memacc operand bundle plus resolved operands and stall status.
interface hazard_wb_unit_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
);
    localparam int RW = $clog2(NREGS);
    logic            id_rs1_v, id_rs2_v;
    logic [RW-1:0]   id_rs1, id_rs2;
    logic            ex_wr, ex_is_load;
    logic [RW-1:0]   ex_rd;
    logic [XLEN-1:0] ex_result;
    logic            mem_wr;
    logic [RW-1:0]   mem_rd;
    logic [XLEN-1:0] mem_result;
    logic [XLEN-1:0] rs1_data, rs2_data;
    logic            stall;
    logic [15:0]     stall_cnt;
    modport slave (
        input  id_rs1_v, id_rs2_v, id_rs1, id_rs2, ex_wr, ex_is_load, ex_rd, ex_result,
               mem_wr, mem_rd, mem_result,
        output rs1_data, rs2_data, stall, stall_cnt
    );
    modport master (
        output id_rs1_v, id_rs2_v, id_rs1, id_rs2, ex_wr, ex_is_load, ex_rd, ex_result,
               mem_wr, mem_rd, mem_result,
        input  rs1_data, rs2_data, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_wb_unit.sv
// hazard_wb_unit: register file with WB stage, operand forwarding and load-use stall.
// Macro HAZARD_WB_UNIT_FWD_EN enables EX/MEM forwarding; otherwise any EX/MEM match stalls.
module hazard_wb_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input logic             clk,
    input logic             rst_n,
    hazard_wb_unit_if.slave bus
);
    localparam int RW = $clog2(NREGS);

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    logic            wb_wr_q, wb_wr_d;
    logic [RW-1:0]   wb_rd_q, wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [15:0]     stall_cnt_q, stall_cnt_d;

    logic [1:0]      op_v, hit, ex_hit, mem_hit, wb_hit, hz;
    logic [RW-1:0]   op_a [2];
    logic [XLEN-1:0] op_d [2];
    logic            stall;

    always_comb begin
        op_v    = {bus.id_rs2_v, bus.id_rs1_v};
        op_a[0] = bus.id_rs1;
        op_a[1] = bus.id_rs2;
        for (int i = 0; i < 2; i++) begin
            hit[i]     = op_v[i] && op_a[i] != '0;
            ex_hit[i]  = hit[i] && bus.ex_wr && bus.ex_rd == op_a[i];
            mem_hit[i] = hit[i] && bus.mem_wr && bus.mem_rd == op_a[i];
            wb_hit[i]  = hit[i] && wb_wr_q && wb_rd_q == op_a[i];
`ifdef HAZARD_WB_UNIT_FWD_EN
            hz[i]   = ex_hit[i] && bus.ex_is_load;
            op_d[i] = !hit[i] ? '0 :
                      (ex_hit[i] && !bus.ex_is_load) ? bus.ex_result :
                      mem_hit[i] ? bus.mem_result :
                      wb_hit[i] ? wb_data_q : rf_q[op_a[i]];
`else
            hz[i]   = ex_hit[i] || mem_hit[i];
            op_d[i] = !hit[i] ? '0 : wb_hit[i] ? wb_data_q : rf_q[op_a[i]];
`endif
        end
    end

`ifndef HAZARD_WB_UNIT_FWD_EN
    logic unused_fwd;
    assign unused_fwd = ^{bus.ex_is_load, bus.ex_result};
`endif

    assign stall         = |hz;
    assign bus.stall     = stall;
    assign bus.rs1_data  = stall ? '0 : op_d[0];
    assign bus.rs2_data  = stall ? '0 : op_d[1];
    assign bus.stall_cnt = stall_cnt_q;

    always_comb begin
        rf_d = rf_q;
        if (wb_wr_q && wb_rd_q != '0) rf_d[wb_rd_q] = wb_data_q;
        wb_wr_d     = bus.mem_wr;
        wb_rd_d     = bus.mem_rd;
        wb_data_d   = bus.mem_result;
        stall_cnt_d = (stall && stall_cnt_q != 16'hFFFF) ? stall_cnt_q + 16'd1 : stall_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
            wb_wr_q     <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            rf_q        <= rf_d;
            wb_wr_q     <= wb_wr_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_wb_unit.sv
// tb_hazard_wb_unit: directed and random checks against an architectural register model.
module tb_hazard_wb_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_wb_unit_if #(.XLEN(32), .NREGS(32)) bus();
    hazard_wb_unit #(.XLEN(32), .NREGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    logic [31:0] arch [32];
    int unsigned m_cnt;
    int n_chk = 0;
    int n_fail = 0;
    int unsigned cnt_before;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic ex_hit(input logic v, input logic [4:0] a);
        return v && a != 0 && bus.ex_wr && bus.ex_rd == a;
    endfunction

    function automatic logic mem_hit(input logic v, input logic [4:0] a);
        return v && a != 0 && bus.mem_wr && bus.mem_rd == a;
    endfunction

    function automatic logic exp_stall();
`ifdef HAZARD_WB_UNIT_FWD_EN
        return bus.ex_is_load && (ex_hit(bus.id_rs1_v, bus.id_rs1) || ex_hit(bus.id_rs2_v, bus.id_rs2));
`else
        return ex_hit(bus.id_rs1_v, bus.id_rs1) || ex_hit(bus.id_rs2_v, bus.id_rs2) ||
               mem_hit(bus.id_rs1_v, bus.id_rs1) || mem_hit(bus.id_rs2_v, bus.id_rs2);
`endif
    endfunction

    function automatic logic [31:0] exp_op(input logic v, input logic [4:0] a);
        if (exp_stall() || !v || a == 0) return 32'h0;
`ifdef HAZARD_WB_UNIT_FWD_EN
        if (ex_hit(v, a) && !bus.ex_is_load) return bus.ex_result;
        if (mem_hit(v, a)) return bus.mem_result;
`endif
        return arch[a];
    endfunction

    task automatic clear_inputs();
        bus.id_rs1_v = 0; bus.id_rs2_v = 0; bus.id_rs1 = 0; bus.id_rs2 = 0;
        bus.ex_wr = 0; bus.ex_is_load = 0; bus.ex_rd = 0; bus.ex_result = 0;
        bus.mem_wr = 0; bus.mem_rd = 0; bus.mem_result = 0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) arch[i] = 32'h0;
        m_cnt = 0;
    endtask

    // Check outputs mid-cycle, then advance the model across the next posedge.
    task automatic step(input string tag);
        #1;
        check({tag, ".rs1"}, bus.rs1_data, exp_op(bus.id_rs1_v, bus.id_rs1));
        check({tag, ".rs2"}, bus.rs2_data, exp_op(bus.id_rs2_v, bus.id_rs2));
        check({tag, ".stall"}, {31'b0, bus.stall}, {31'b0, exp_stall()});
        check({tag, ".cnt"}, {16'b0, bus.stall_cnt}, m_cnt);
        @(posedge clk);
        if (rst_n) begin
            if (bus.mem_wr && bus.mem_rd != 0) arch[bus.mem_rd] = bus.mem_result;
            if (exp_stall() && m_cnt < 65535) m_cnt++;
        end
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        clear_inputs();
        bus.id_rs1_v = 1; bus.id_rs1 = 4; bus.ex_wr = 1; bus.ex_rd = 4; bus.ex_is_load = 1;
        #1;
        check("rst_stall_comb", {31'b0, bus.stall}, 32'h1);
        check("rst_cnt", {16'b0, bus.stall_cnt}, 32'h0);
        clear_inputs();
        bus.id_rs1_v = 1; bus.id_rs1 = 5;
        #1;
        check("rst_x5", bus.rs1_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1;
        step("idle");

        clear_inputs();
        bus.ex_wr = 1; bus.ex_rd = 3; bus.ex_result = 32'hAA; bus.id_rs1_v = 1; bus.id_rs1 = 3;
        #1;
`ifdef HAZARD_WB_UNIT_FWD_EN
        check("ex_fwd", bus.rs1_data, 32'hAA);
        check("ex_fwd_stall", {31'b0, bus.stall}, 32'h0);
`else
        check("ex_nofwd_stall", {31'b0, bus.stall}, 32'h1);
`endif
        step("ex_fwd");

        clear_inputs();
        bus.ex_wr = 1; bus.ex_rd = 7; bus.ex_result = 32'h1;
        bus.mem_wr = 1; bus.mem_rd = 7; bus.mem_result = 32'h2;
        bus.id_rs2_v = 1; bus.id_rs2 = 7; bus.id_rs1_v = 1; bus.id_rs1 = 7;
        #1;
`ifdef HAZARD_WB_UNIT_FWD_EN
        check("prio_rs2", bus.rs2_data, 32'h1);
        check("prio_rs1", bus.rs1_data, 32'h1);
`else
        check("prio_nofwd_stall", {31'b0, bus.stall}, 32'h1);
`endif
        step("prio");

        clear_inputs();
        bus.ex_wr = 1; bus.ex_is_load = 1; bus.ex_rd = 4; bus.ex_result = 32'h55;
        bus.id_rs1_v = 1; bus.id_rs1 = 4; bus.id_rs2_v = 1; bus.id_rs2 = 7;
        #1;
        cnt_before = {16'b0, bus.stall_cnt};
        check("lu_stall", {31'b0, bus.stall}, 32'h1);
        check("lu_rs1", bus.rs1_data, 32'h0);
        check("lu_rs2", bus.rs2_data, 32'h0);
        step("lu");
        clear_inputs();
        #1;
        check("lu_cnt_inc", {16'b0, bus.stall_cnt}, cnt_before + 1);
        check("lu_release", {31'b0, bus.stall}, 32'h0);

        bus.mem_wr = 1; bus.mem_rd = 0; bus.mem_result = 32'hFF; bus.id_rs1_v = 1; bus.id_rs1 = 0;
        step("x0_w");
        clear_inputs();
        bus.id_rs1_v = 1; bus.id_rs1 = 0;
        step("x0_a");
        step("x0_b");
        check("x0_read", bus.rs1_data, 32'h0);

        clear_inputs();
        bus.mem_wr = 1; bus.mem_rd = 5; bus.mem_result = 32'h1234;
        step("x5_w");
        clear_inputs();
        bus.id_rs1_v = 1; bus.id_rs1 = 5;
        step("x5_wb_bypass");
        step("x5_rf");
        #1;
        check("x5_before_rst", bus.rs1_data, 32'h1234);
        rst_n = 0;
        #1;
        model_reset();
        check("x5_after_rst", bus.rs1_data, 32'h0);
        check("cnt_after_rst", {16'b0, bus.stall_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        step("post_rst");

        for (int k = 0; k < 400; k++) begin
            bus.id_rs1_v = ($urandom_range(0, 3) != 0);
            bus.id_rs2_v = ($urandom_range(0, 3) != 0);
            bus.id_rs1 = 5'($urandom_range(0, 7));
            bus.id_rs2 = 5'($urandom_range(0, 7));
            bus.ex_wr = ($urandom_range(0, 2) == 0);
            bus.ex_is_load = ($urandom_range(0, 3) == 0);
            bus.ex_rd = 5'($urandom_range(0, 7));
            bus.ex_result = $urandom;
            bus.mem_wr = ($urandom_range(0, 1) == 0);
            bus.mem_rd = 5'($urandom_range(0, 7));
            bus.mem_result = $urandom;
            step("rand");
        end

        clear_inputs();
        bus.mem_wr = 1; bus.mem_rd = 9; bus.mem_result = 32'h99; bus.id_rs1_v = 1; bus.id_rs1 = 9;
        #1;
`ifdef HAZARD_WB_UNIT_FWD_EN
        check("mem_fwd", bus.rs1_data, 32'h99);
        check("mem_fwd_stall", {31'b0, bus.stall}, 32'h0);
`else
        check("nofwd_mem_stall", {31'b0, bus.stall}, 32'h1);
`endif
        step("mem9");

        clear_inputs();
        bus.ex_wr = 1; bus.ex_is_load = 1; bus.ex_rd = 4; bus.id_rs1_v = 1; bus.id_rs1 = 4;
        repeat (70000) @(negedge clk);
        m_cnt = 65535;
        #1;
        check("sat", {16'b0, bus.stall_cnt}, 32'hFFFF);
        step("sat_hold");
        step("sat_hold2");
        clear_inputs();
        step("end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
